goldilocks_mul_red: RTL and testbench

- Pipelined modular multiplier over the Goldilocks prime p = 2^64 - 2^32 + 1.
- Forms the full 128-bit product of two 64-bit operands, then folds it to 64 bits with the shift/add reduction for p.
- Used in NTT butterflies; one new operand pair accepted every enabled cycle.

---
 rtl/goldilocks_mul_red.sv | 172 +++++++++++++++++
 tb/tb_goldilocks_mul_red.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/goldilocks_mul_red.sv
// Pipelined multiplier mod p = 2^64 - 2^32 + 1: four multiply stages, three reduce stages.
// Define GOLDILOCKS_MULRED_CHECK_EN to add a simulation-only self-check of r_o.
`timescale 1ns/1ps

module goldilocks_mul_red #(
    parameter int BFLYDSP = 24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] r_o
);

    localparam logic [63:0] L_P     = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] L_NEG_P = 64'h0000_0000_FFFF_FFFF;  // -p mod 2^64

    localparam bit L_NARROW_DSP = !(BFLYDSP == 24 || BFLYDSP == 16 || BFLYDSP == 12);
    localparam bit L_WIDE_DSP   = (BFLYDSP != 12);

    logic [63:0] r_a, r_b;
    logic [63:0] r_pp_ll, r_pp_lh, r_pp_hl, r_pp_hh;
    logic [63:0] r_m2_ll, r_m2_hh;
    logic [64:0] r_cross;
    logic [64:0] r_lo_sum;
    logic [63:0] r_m3_hh;
    logic [32:0] r_cross_hi;
    logic [63:0] r_prod_lo, r_prod_hi;
    logic [65:0] r_lo_m_hi;
    logic [63:0] r_mid_term;
    logic [65:0] r_t;

    logic [63:0] w_mid_term;
    logic [65:0] w_lo_m_hi;
    logic [65:0] w_t;
    logic [63:0] w_corr;

    // mid*2^32 - mid never goes negative and always fits in 64 bits
    generate
        if (L_NARROW_DSP) begin : g_mid_dsp
            (* use_dsp = "yes" *) logic [63:0] w_v;
            assign w_v = {r_prod_hi[31:0], 32'd0} - {32'd0, r_prod_hi[31:0]};
            assign w_mid_term = w_v;
        end else begin : g_mid_fab
            (* use_dsp = "no" *) logic [63:0] w_v;
            assign w_v = {r_prod_hi[31:0], 32'd0} - {32'd0, r_prod_hi[31:0]};
            assign w_mid_term = w_v;
        end

        if (L_WIDE_DSP) begin : g_wide_dsp
            (* use_dsp = "yes" *) logic [65:0] w_sub;
            (* use_dsp = "yes" *) logic [65:0] w_add;
            assign w_sub     = {2'b00, r_prod_lo} - {34'd0, r_prod_hi[63:32]};
            assign w_add     = r_lo_m_hi + {2'b00, r_mid_term};
            assign w_lo_m_hi = w_sub;
            assign w_t       = w_add;
        end else begin : g_wide_fab
            (* use_dsp = "no" *) logic [65:0] w_sub;
            (* use_dsp = "no" *) logic [65:0] w_add;
            assign w_sub     = {2'b00, r_prod_lo} - {34'd0, r_prod_hi[63:32]};
            assign w_add     = r_lo_m_hi + {2'b00, r_mid_term};
            assign w_lo_m_hi = w_sub;
            assign w_t       = w_add;
        end
    endgenerate

    // t is a 66-bit two's-complement value: bit 65 = negative, bit 64 = at or above 2^64
    always_comb begin
        // NOTE: default assigned first so no path through this block can infer a latch.
        w_corr = r_t[63:0];
        if (r_t[65]) begin
            w_corr = r_t[63:0] + L_P;
        end else if (r_t[64]) begin
            w_corr = r_t[63:0] + L_NEG_P;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the data registers are reset too, since r_o must read 0 until real results flush through.
        if (!rst_ni) begin
            r_a        <= '0;
            r_b        <= '0;
            r_pp_ll    <= '0;
            r_pp_lh    <= '0;
            r_pp_hl    <= '0;
            r_pp_hh    <= '0;
            r_m2_ll    <= '0;
            r_m2_hh    <= '0;
            r_cross    <= '0;
            r_lo_sum   <= '0;
            r_m3_hh    <= '0;
            r_cross_hi <= '0;
            r_prod_lo  <= '0;
            r_prod_hi  <= '0;
            r_lo_m_hi  <= '0;
            r_mid_term <= '0;
            r_t        <= '0;
            r_o        <= '0;
        end else if (ce_i) begin
            // NOTE: non-blocking assignments make every stage read last cycle's values.
            r_a        <= a_i;
            r_b        <= b_i;
            r_pp_ll    <= 64'(r_a[31:0])  * 64'(r_b[31:0]);
            r_pp_lh    <= 64'(r_a[31:0])  * 64'(r_b[63:32]);
            r_pp_hl    <= 64'(r_a[63:32]) * 64'(r_b[31:0]);
            r_pp_hh    <= 64'(r_a[63:32]) * 64'(r_b[63:32]);
            r_m2_ll    <= r_pp_ll;
            r_m2_hh    <= r_pp_hh;
            r_cross    <= {1'b0, r_pp_lh} + {1'b0, r_pp_hl};
            r_lo_sum   <= {1'b0, r_m2_ll} + {1'b0, r_cross[31:0], 32'd0};
            r_m3_hh    <= r_m2_hh;
            r_cross_hi <= r_cross[64:32];
            r_prod_lo  <= r_lo_sum[63:0];
            r_prod_hi  <= r_m3_hh + {31'd0, r_cross_hi} + {63'd0, r_lo_sum[64]};
            r_lo_m_hi  <= w_lo_m_hi;
            r_mid_term <= w_mid_term;
            r_t        <= w_t;
            r_o        <= w_corr;
        end
    end

`ifdef GOLDILOCKS_MULRED_CHECK_EN
    localparam int L_LAT = 7;

    logic [63:0]    r_chk_a [0:L_LAT];
    logic [63:0]    r_chk_b [0:L_LAT];
    logic [L_LAT:0] r_chk_vld;

    function automatic logic [63:0] chk_ref(input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       prod;
        logic signed [67:0] t;
        prod = 128'(a) * 128'(b);
        t = $signed({4'd0, prod[63:0]}) - $signed({36'd0, prod[127:96]})
          + $signed({36'd0, prod[95:64]}) * 68'sh1_0000_0000
          - $signed({36'd0, prod[95:64]});
        if (t < 0)
            t = t + $signed({4'd0, L_P});
        else if (t >= 68'sh1_0000_0000_0000_0000)
            t = t - $signed({4'd0, L_P});
        return t[63:0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_chk_vld <= '0;
        else if (ce_i)
            r_chk_vld <= {r_chk_vld[L_LAT-1:0], 1'b1};
    end

    // operand history only matters where the valid bit is set, so it stays unreset
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            r_chk_a[0] <= a_i;
            r_chk_b[0] <= b_i;
            for (int i = 1; i <= L_LAT; i++) begin
                r_chk_a[i] <= r_chk_a[i-1];
                r_chk_b[i] <= r_chk_b[i-1];
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && r_chk_vld[L_LAT] && r_o !== chk_ref(r_chk_a[L_LAT], r_chk_b[L_LAT])) begin
            $display("goldilocks_mul_red check: a=%h b=%h got=%h want=%h",
                     r_chk_a[L_LAT], r_chk_b[L_LAT], r_o, chk_ref(r_chk_a[L_LAT], r_chk_b[L_LAT]));
            $fatal(1, "goldilocks_mul_red self-check");
        end
    end
`endif

endmodule

// File: tb/tb_goldilocks_mul_red.sv
// Bench for goldilocks_mul_red: directed corner products, a random stream with stalls,
// a mid-stream asynchronous reset and a long stall, all scored against a queue of expectations.
`timescale 1ns/1ps

module tb_goldilocks_mul_red;

    localparam int          LAT   = 7;
    localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ce_i;
    logic [63:0] a_i, b_i;
    logic [63:0] r_o;

    goldilocks_mul_red dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ce_i   (ce_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .r_o    (r_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned due;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned en_cnt = 0;
    logic [63:0] prev_r = '0;

    // Reference: full 128-bit product, then the fold applied with plain signed integers.
    function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       prod;
        logic signed [67:0] lo, mid, hi, t;
        prod = 128'(a) * 128'(b);
        lo   = $signed({4'd0, prod[63:0]});
        mid  = $signed({36'd0, prod[95:64]});
        hi   = $signed({36'd0, prod[127:96]});
        t    = lo - hi + mid * 68'sh1_0000_0000 - mid;
        if (t < 0)
            t = t + $signed({4'd0, P_MOD});
        else if (t >= 68'sh1_0000_0000_0000_0000)
            t = t - $signed({4'd0, P_MOD});
        return t[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Drive one cycle; an enabled sample is due LAT enabled edges after the edge that takes it.
    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic ce,
                         input logic [63:0] exp, input logic push);
        @(negedge clk_i);
        a_i  = a;
        b_i  = b;
        ce_i = ce;
        if (ce && push)
            sb_q.push_back('{due: en_cnt + 1 + LAT, a: a, b: b, exp: exp});
    endtask

    task automatic drive_rand(input logic ce);
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) a = P_MOD - 64'(1 + $urandom_range(0, 3));
        drive(a, b, ce, ref_model(a, b), 1'b1);
    endtask

    // After release the pipeline holds zeros, so the next LAT enabled outputs must read 0.
    task automatic release_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 1; i <= LAT; i++)
            sb_q.push_back('{due: en_cnt + i, a: '0, b: '0, exp: '0});
    endtask

    // Monitor: scores each enabled edge against the queue head, and checks r_o holds on stalls.
    initial begin : monitor
        logic ce_s, rst_s;
        sb_t  e;
        forever begin
            @(posedge clk_i);
            ce_s  = ce_i;
            rst_s = rst_ni;
            #1;
            if (rst_s && rst_ni) begin
                if (ce_s) begin
                    en_cnt++;
                    while (sb_q.size() > 0 && sb_q[0].due < en_cnt) begin
                        e = sb_q.pop_front();
                        check($sformatf("missed a=%h b=%h", e.a, e.b), r_o, e.exp);
                    end
                    if (sb_q.size() > 0 && sb_q[0].due == en_cnt) begin
                        e = sb_q.pop_front();
                        check($sformatf("result a=%h b=%h", e.a, e.b), r_o, e.exp);
                    end
                end else begin
                    check("stall_hold", r_o, prev_r);
                end
            end
            prev_r = r_o;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int pushed;
        rst_ni = 1'b0;
        ce_i   = 1'b0;
        a_i    = '0;
        b_i    = '0;
        #1;
        check("reset_state", r_o, 64'd0);
        repeat (3) @(negedge clk_i);
        release_reset();

        // Directed corner products, expectations worked out by hand.
        drive(64'd2, 64'd3, 1'b1, 64'h0000_0000_0000_0006, 1'b1);
        drive(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
        drive(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1);
        drive(64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFC_0000_0004, 1'b1);
        drive(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1);

        // Random stream with bubbles; an asynchronous reset lands mid-stream.
        pushed = 0;
        while (pushed < 1000) begin
            if (pushed == 500) begin
                drive_rand(1'b1);
                #2;
                rst_ni = 1'b0;
                #1;
                check("reset_async", r_o, 64'd0);
                sb_q.delete();
                ce_i = 1'b0;
                repeat (3) @(negedge clk_i);
                release_reset();
                pushed++;
            end
            if ($urandom_range(0, 3) == 0) begin
                drive_rand(1'b0);
            end else begin
                drive_rand(1'b1);
                pushed++;
            end
        end

        // Long stall with toggling inputs, then resume the stream.
        for (int i = 0; i < 20; i++)
            drive_rand(1'b0);
        for (int i = 0; i < 30; i++)
            drive_rand(1'b1);

        // Flush the pipeline with unscored zeros until every expectation is consumed.
        for (int i = 0; i < 4 * LAT && sb_q.size() > 0; i++)
            drive(64'd0, 64'd0, 1'b1, 64'd0, 1'b0);
        @(negedge clk_i);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
